// File: rtl/phy_pkg.sv
// Shared constants, state encoding and sizing helper for the serial PHY blocks.
package phy_pkg;

    localparam logic [7:0] COM_DEFAULT = 8'hBC;
    localparam logic [7:0] IDL_DEFAULT = 8'h7C;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } phy_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serializer_shift.sv
// Symbol shift register and bit counter; reloads from load_data on every symbol boundary.
module serializer_shift
    import phy_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] load_data,
    output logic              boundary,
    output logic              data_out,
    output logic              symbol_start
);

    localparam int CW = cnt_width(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    assign boundary = (cnt_q == LAST);

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (boundary) begin
            sh_d  = load_data;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (MSB_FIRST) begin
                sh_d = {sh_q[DATA_W-2:0], 1'b0};
            end else begin
                sh_d = {1'b0, sh_q[DATA_W-1:1]};
            end
        end
    end

    // cnt resets to the last bit so the first edge after release is a boundary
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            sh_q  <= '0;
            cnt_q <= LAST;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign data_out     = MSB_FIRST ? sh_q[DATA_W-1] : sh_q[0];
    assign symbol_start = (cnt_q == '0) && reset_L;

endmodule

// File: rtl/paralelo_serial_tx_param.sv
// Parallel-to-serial PHY transmitter: COM training run, then user words or IDL fillers.
module paralelo_serial_tx_param
    import phy_pkg::*;
#(
    parameter int              DATA_W     = 8,
    parameter logic [DATA_W-1:0] COM_SYM  = DATA_W'(COM_DEFAULT),
    parameter logic [DATA_W-1:0] IDL_SYM  = DATA_W'(IDL_DEFAULT),
    parameter int              SYNC_COUNT = 4,
    parameter bit              MSB_FIRST  = 1'b1
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic              active,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              data_out,
    output logic              symbol_start,
    output logic              link_up
);

    localparam int CCW = cnt_width(SYNC_COUNT + 1);
    localparam logic [CCW-1:0] COM_TARGET = CCW'(SYNC_COUNT);

    phy_state_e        state_q, state_d;
    logic [CCW-1:0]    com_cnt_q, com_cnt_d;
    logic [DATA_W-1:0] next_sym;
    logic              boundary;

    serializer_shift #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk_32f      (clk_32f),
        .reset_L      (reset_L),
        .load_data    (next_sym),
        .boundary     (boundary),
        .data_out     (data_out),
        .symbol_start (symbol_start)
    );

    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        next_sym  = COM_SYM;
        in_ready  = 1'b0;
        if (boundary) begin
            unique case (state_q)
                SYNC: begin
                    if ((com_cnt_q == COM_TARGET) && active) begin
                        state_d  = ACTIVE;
                        in_ready = 1'b1;
                        next_sym = in_valid ? in_data : IDL_SYM;
                    end else if (com_cnt_q != COM_TARGET) begin
                        com_cnt_d = com_cnt_q + CCW'(1);
                    end
                end
                ACTIVE: begin
                    // the COM sent on leaving counts as the first of the new run
                    if (!active) begin
                        state_d   = SYNC;
                        com_cnt_d = CCW'(1);
                    end else begin
                        in_ready = 1'b1;
                        next_sym = in_valid ? in_data : IDL_SYM;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= SYNC;
            com_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            com_cnt_q <= com_cnt_d;
        end
    end

    assign link_up = (state_q == ACTIVE);

endmodule

// File: tb/tb_paralelo_serial_tx_param.sv
// Directed bench: default 8-bit MSB-first instance plus a 10-bit LSB-first instance.
module tb_paralelo_serial_tx_param;

    logic clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    logic       reset_L_a = 1'b0, active_a = 1'b0, in_valid_a = 1'b0;
    logic [7:0] in_data_a = 8'h00;
    logic       in_ready_a, data_out_a, symbol_start_a, link_up_a;

    logic       reset_L_b = 1'b0, active_b = 1'b0, in_valid_b = 1'b0;
    logic [9:0] in_data_b = 10'h000;
    logic       in_ready_b, data_out_b, symbol_start_b, link_up_b;

    int total = 0;
    int bad   = 0;

    bit qa_do[$], qa_ss[$], qa_rdy[$], qa_lk[$], qa_hs[$];
    bit qb_do[$], qb_ss[$], qb_rdy[$], qb_lk[$];

    paralelo_serial_tx_param dut_a (
        .clk_32f      (clk_32f),
        .reset_L      (reset_L_a),
        .active       (active_a),
        .in_data      (in_data_a),
        .in_valid     (in_valid_a),
        .in_ready     (in_ready_a),
        .data_out     (data_out_a),
        .symbol_start (symbol_start_a),
        .link_up      (link_up_a)
    );

    paralelo_serial_tx_param #(
        .DATA_W     (10),
        .COM_SYM    (10'h17C),
        .SYNC_COUNT (2),
        .MSB_FIRST  (1'b0)
    ) dut_b (
        .clk_32f      (clk_32f),
        .reset_L      (reset_L_b),
        .active       (active_b),
        .in_data      (in_data_b),
        .in_valid     (in_valid_b),
        .in_ready     (in_ready_b),
        .data_out     (data_out_b),
        .symbol_start (symbol_start_b),
        .link_up      (link_up_b)
    );

    always @(negedge clk_32f) begin
        qa_do.push_back(data_out_a);
        qa_ss.push_back(symbol_start_a);
        qa_rdy.push_back(in_ready_a);
        qa_lk.push_back(link_up_a);
        qa_hs.push_back(in_ready_a && in_valid_a);
        qb_do.push_back(data_out_b);
        qb_ss.push_back(symbol_start_b);
        qb_rdy.push_back(in_ready_b);
        qb_lk.push_back(link_up_b);
    end

    task automatic clear_a();
        qa_do.delete(); qa_ss.delete(); qa_rdy.delete(); qa_lk.delete(); qa_hs.delete();
    endtask

    task automatic clear_b();
        qb_do.delete(); qb_ss.delete(); qb_rdy.delete(); qb_lk.delete();
    endtask

    task automatic wait_a(input int n);
        int g = 0;
        while (qa_do.size() < n && g < 2000) begin
            @(negedge clk_32f); #1;
            g++;
        end
        if (qa_do.size() < n) begin
            total++; bad++;
            $display("FAIL wait_a got=%0d samples want=%0d", qa_do.size(), n);
        end
    endtask

    task automatic wait_b(input int n);
        int g = 0;
        while (qb_do.size() < n && g < 2000) begin
            @(negedge clk_32f); #1;
            g++;
        end
        if (qb_do.size() < n) begin
            total++; bad++;
            $display("FAIL wait_b got=%0d samples want=%0d", qb_do.size(), n);
        end
    endtask

    // leaves us at posedge+1 just after a boundary edge of dut_a
    task automatic align_a();
        int g = 0;
        do begin
            @(negedge clk_32f);
            g++;
        end while (!symbol_start_a && g < 40);
        if (!symbol_start_a) begin
            total++; bad++;
            $display("FAIL align_a got=no symbol_start want=symbol_start within 40 cycles");
        end
        repeat (8) @(posedge clk_32f);
        #1;
    endtask

    task automatic test_reset();
        active_a = 1'b1; in_valid_a = 1'b1; in_data_a = 8'hFF;
        active_b = 1'b1; in_valid_b = 1'b1; in_data_b = 10'h3FF;
        repeat (3) @(negedge clk_32f);
        total++; if (data_out_a !== 1'b0)     begin bad++; $display("FAIL rst_a_data got=%b want=0", data_out_a); end
        total++; if (symbol_start_a !== 1'b0) begin bad++; $display("FAIL rst_a_ss got=%b want=0", symbol_start_a); end
        total++; if (link_up_a !== 1'b0)      begin bad++; $display("FAIL rst_a_link got=%b want=0", link_up_a); end
        total++; if (in_ready_a !== 1'b0)     begin bad++; $display("FAIL rst_a_ready got=%b want=0", in_ready_a); end
        total++; if (data_out_b !== 1'b0)     begin bad++; $display("FAIL rst_b_data got=%b want=0", data_out_b); end
        total++; if (in_ready_b !== 1'b0)     begin bad++; $display("FAIL rst_b_ready got=%b want=0", in_ready_b); end
        in_valid_a = 1'b0; in_valid_b = 1'b0;
    endtask

    task automatic test_sync_idle();
        logic [7:0] v, exp;
        @(negedge clk_32f); #1;
        clear_a();
        reset_L_a = 1'b1;
        wait_a(48);
        for (int j = 0; j < 6; j++) begin
            v = '0;
            for (int i = 0; i < 8; i++) v = {v[6:0], qa_do[8*j+i]};
            exp = (j < 4) ? 8'hBC : 8'h7C;
            total++;
            if (v !== exp) begin bad++; $display("FAIL sync_sym%0d got=%h want=%h", j, v, exp); end
        end
        for (int s = 0; s < 48; s++) begin
            total++;
            if (qa_ss[s] !== (s % 8 == 0)) begin bad++; $display("FAIL sync_ss[%0d] got=%b want=%b", s, qa_ss[s], (s % 8 == 0)); end
            total++;
            if (qa_lk[s] !== (s >= 32)) begin bad++; $display("FAIL sync_link[%0d] got=%b want=%b", s, qa_lk[s], (s >= 32)); end
            total++;
            if (qa_rdy[s] !== (s == 31 || s == 39 || s == 47)) begin
                bad++; $display("FAIL sync_ready[%0d] got=%b want=%b", s, qa_rdy[s], (s == 31 || s == 39 || s == 47));
            end
        end
    endtask

    task automatic test_single_word();
        logic [7:0] v;
        int hs;
        align_a();
        clear_a();
        in_data_a = 8'hA5; in_valid_a = 1'b1;
        wait_a(8);
        @(posedge clk_32f); #1;
        in_valid_a = 1'b0;
        wait_a(24);
        for (int j = 0; j < 3; j++) begin
            v = '0;
            for (int i = 0; i < 8; i++) v = {v[6:0], qa_do[8*j+i]};
            total++;
            if (v !== ((j == 1) ? 8'hA5 : 8'h7C)) begin bad++; $display("FAIL word_sym%0d got=%h want=%h", j, v, (j == 1) ? 8'hA5 : 8'h7C); end
        end
        hs = 0;
        for (int s = 0; s < 24; s++) hs += qa_hs[s];
        total++; if (hs != 1) begin bad++; $display("FAIL word_handshakes got=%0d want=1", hs); end
        total++; if (qa_rdy[7] !== 1'b1) begin bad++; $display("FAIL word_ready7 got=%b want=1", qa_rdy[7]); end
        for (int s = 0; s < 7; s++) begin
            total++;
            if (qa_rdy[s] !== 1'b0) begin bad++; $display("FAIL word_ready[%0d] got=%b want=0", s, qa_rdy[s]); end
        end
        total++; if (qa_ss[8] !== 1'b1) begin bad++; $display("FAIL word_ss8 got=%b want=1", qa_ss[8]); end
    endtask

    task automatic test_active_drop();
        logic [7:0] v, exp;
        int hs;
        align_a();
        clear_a();
        in_data_a = 8'h3C; in_valid_a = 1'b1;
        wait_a(8);  @(posedge clk_32f); #1; in_valid_a = 1'b0;
        wait_a(11); @(posedge clk_32f); #1; active_a = 1'b0;
        wait_a(12); @(posedge clk_32f); #1; in_data_a = 8'h55; in_valid_a = 1'b1;
        wait_a(51); @(posedge clk_32f); #1; active_a = 1'b1;
        wait_a(56); @(posedge clk_32f); #1; in_valid_a = 1'b0;
        wait_a(72);
        for (int j = 1; j < 9; j++) begin
            v = '0;
            for (int i = 0; i < 8; i++) v = {v[6:0], qa_do[8*j+i]};
            exp = (j == 1) ? 8'h3C : (j <= 6) ? 8'hBC : (j == 7) ? 8'h55 : 8'h7C;
            total++;
            if (v !== exp) begin bad++; $display("FAIL drop_sym%0d got=%h want=%h", j, v, exp); end
        end
        total++; if (qa_lk[15] !== 1'b1) begin bad++; $display("FAIL drop_link15 got=%b want=1", qa_lk[15]); end
        for (int s = 16; s < 56; s++) begin
            total++;
            if (qa_lk[s] !== 1'b0) begin bad++; $display("FAIL drop_link[%0d] got=%b want=0", s, qa_lk[s]); end
        end
        total++; if (qa_lk[56] !== 1'b1)  begin bad++; $display("FAIL drop_link56 got=%b want=1", qa_lk[56]); end
        total++; if (qa_rdy[15] !== 1'b0) begin bad++; $display("FAIL drop_ready15 got=%b want=0", qa_rdy[15]); end
        total++; if (qa_rdy[55] !== 1'b1) begin bad++; $display("FAIL drop_ready55 got=%b want=1", qa_rdy[55]); end
        hs = 0;
        for (int s = 0; s < 72; s++) hs += qa_hs[s];
        total++; if (hs != 2) begin bad++; $display("FAIL drop_handshakes got=%0d want=2", hs); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] v;
        logic [7:0]  t;
        int hs;
        int g;
        align_a();
        clear_a();
        in_data_a = 8'h01; in_valid_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            g = 0;
            do begin
                @(negedge clk_32f);
                g++;
            end while (!in_ready_a && g < 20);
            if (!in_ready_a) begin
                total++; bad++;
                $display("FAIL b2b_wait%0d got=no in_ready want=in_ready within 20 cycles", k);
            end
            @(posedge clk_32f); #1;
            if (k < 2) in_data_a = 8'(k + 2);
            else       in_valid_a = 1'b0;
        end
        wait_a(40);
        v = '0;
        for (int s = 8; s < 32; s++) v = {v[22:0], qa_do[s]};
        total++; if (v !== 24'h010203) begin bad++; $display("FAIL b2b_stream got=%h want=010203", v); end
        t = '0;
        for (int s = 32; s < 40; s++) t = {t[6:0], qa_do[s]};
        total++; if (t !== 8'h7C) begin bad++; $display("FAIL b2b_idle got=%h want=7c", t); end
        hs = 0;
        for (int s = 0; s < 40; s++) hs += qa_hs[s];
        total++; if (hs != 3) begin bad++; $display("FAIL b2b_handshakes got=%0d want=3", hs); end
        for (int s = 0; s < 24; s++) begin
            total++;
            if (qa_rdy[s] !== (s % 8 == 7)) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=%b", s, qa_rdy[s], (s % 8 == 7)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        align_a();
        clear_a();
        in_data_a = 8'hF0; in_valid_a = 1'b1;
        wait_a(8);  @(posedge clk_32f); #1; in_valid_a = 1'b0;
        wait_a(11); @(posedge clk_32f); #1;
        total++; if (data_out_a !== 1'b1) begin bad++; $display("FAIL rmid_bit3 got=%b want=1", data_out_a); end
        reset_L_a = 1'b0;
        #1;
        total++; if (data_out_a !== 1'b0) begin bad++; $display("FAIL rmid_data got=%b want=0", data_out_a); end
        total++; if (link_up_a !== 1'b0)  begin bad++; $display("FAIL rmid_link got=%b want=0", link_up_a); end
        repeat (3) @(negedge clk_32f);
        total++; if (data_out_a !== 1'b0) begin bad++; $display("FAIL rmid_hold got=%b want=0", data_out_a); end
        total++; if (symbol_start_a !== 1'b0) begin bad++; $display("FAIL rmid_ss got=%b want=0", symbol_start_a); end
        #1;
        clear_a();
        reset_L_a = 1'b1;
        wait_a(40);
        for (int j = 0; j < 5; j++) begin
            v = '0;
            for (int i = 0; i < 8; i++) v = {v[6:0], qa_do[8*j+i]};
            total++;
            if (v !== ((j < 4) ? 8'hBC : 8'h7C)) begin bad++; $display("FAIL rmid_sym%0d got=%h want=%h", j, v, (j < 4) ? 8'hBC : 8'h7C); end
        end
        total++; if (qa_ss[0] !== 1'b1)  begin bad++; $display("FAIL rmid_ss0 got=%b want=1", qa_ss[0]); end
        total++; if (qa_lk[31] !== 1'b0) begin bad++; $display("FAIL rmid_link31 got=%b want=0", qa_lk[31]); end
        total++; if (qa_lk[32] !== 1'b1) begin bad++; $display("FAIL rmid_link32 got=%b want=1", qa_lk[32]); end
    endtask

    task automatic test_w10();
        logic [9:0] v, exp;
        @(negedge clk_32f); #1;
        clear_b();
        in_data_b = 10'h2AB; in_valid_b = 1'b1; active_b = 1'b1;
        reset_L_b = 1'b1;
        wait_b(20); @(posedge clk_32f); #1; in_valid_b = 1'b0;
        wait_b(40);
        for (int j = 0; j < 4; j++) begin
            v = '0;
            for (int i = 0; i < 10; i++) v[i] = qb_do[10*j+i];
            exp = (j < 2) ? 10'h17C : (j == 2) ? 10'h2AB : 10'h07C;
            total++;
            if (v !== exp) begin bad++; $display("FAIL w10_sym%0d got=%h want=%h", j, v, exp); end
        end
        for (int s = 0; s < 40; s++) begin
            total++;
            if (qb_ss[s] !== (s % 10 == 0)) begin bad++; $display("FAIL w10_ss[%0d] got=%b want=%b", s, qb_ss[s], (s % 10 == 0)); end
        end
        total++; if (qb_lk[19] !== 1'b0)  begin bad++; $display("FAIL w10_link19 got=%b want=0", qb_lk[19]); end
        total++; if (qb_lk[20] !== 1'b1)  begin bad++; $display("FAIL w10_link20 got=%b want=1", qb_lk[20]); end
        total++; if (qb_rdy[9] !== 1'b0)  begin bad++; $display("FAIL w10_ready9 got=%b want=0", qb_rdy[9]); end
        total++; if (qb_rdy[19] !== 1'b1) begin bad++; $display("FAIL w10_ready19 got=%b want=1", qb_rdy[19]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sync_idle();
        test_single_word();
        test_active_drop();
        test_back_to_back();
        test_reset_mid();
        test_w10();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/paralelo_serial_tx_param.md
# paralelo_serial_tx_param

- Parametrised parallel-to-serial PHY transmitter, running on the serial-rate clock.
- Serialises DATA_W-bit symbols one bit per clock.
- After reset it sends a training run of COM symbols. It then sends IDL fillers, or user words accepted through a valid/ready handshake.
- Feeds the serial→parallel PHY RX: its COM/IDL framing is what the receiver aligns on.

## Interface
Parameters:
- DATA_W, 8, symbol width in bits (≥4)
- COM_SYM, 8'hBC (DATA_W bits), comma/alignment symbol
- IDL_SYM, 8'h7C (DATA_W bits), idle filler symbol
- SYNC_COUNT, 4, minimum consecutive COM symbols before link-up (≥1)
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first

Ports:
- clk_32f  in  1  serial-rate clock, single clock domain
- reset_L  in  1  asynchronous, active-low reset
- active  in  1  upstream enable; sampled only at symbol boundaries
- in_data  in  DATA_W  word to transmit
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle (combinational)
- data_out  out  1  serial bit
- symbol_start  out  1  high while data_out carries the first bit of a symbol
- link_up  out  1  high in state ACTIVE

## Operation
- Registers:
  - shift register sh[DATA_W-1:0]
  - bit counter cnt, $clog2(DATA_W) bits, range 0..DATA_W-1
  - COM counter com_cnt, saturating at SYNC_COUNT
  - state {SYNC, ACTIVE}
- Reset (reset_L=0, async), values held until the first edge after release:
  - sh=0, cnt=DATA_W-1, com_cnt=0, state=SYNC
  - data_out=0, symbol_start=0, link_up=0, in_ready=0
- Boundary: a clock edge with cnt==DATA_W-1.
  - Loads the next symbol into sh and sets cnt=0.
  - Otherwise cnt increments and sh shifts by one toward the output bit.
- data_out = sh[DATA_W-1] if MSB_FIRST, else sh[0].
- symbol_start = (cnt==0) and not in reset.
- SYNC state:
  - At each boundary, load COM_SYM and increment com_cnt (saturating).
  - Go to ACTIVE at a boundary where com_cnt==SYNC_COUNT (i.e. SYNC_COUNT COMs already fully sent) and active==1.
  - That same boundary loads the first ACTIVE symbol; no extra COM is sent.
- ACTIVE state, at each boundary:
  - active==0 → load COM_SYM, state=SYNC, com_cnt=1. The COM counts toward the new training run.
  - else in_valid==1 → load in_data (handshake completes).
  - else → load IDL_SYM.
- in_ready = (cnt==DATA_W-1) && active && the next state is ACTIVE, which covers both staying in ACTIVE and entering it this boundary.
  - in_ready is never high outside a boundary cycle.
  - The upstream must hold in_valid/in_data until in_ready.
- Words equal to COM_SYM/IDL_SYM are sent unmodified. Avoiding them is the upstream's responsibility.

## Timing
- Symbol period: exactly DATA_W clocks, no gaps, continuous from the first edge after reset release.
- First COM: its first bit appears on data_out after the first rising edge following reset release, with symbol_start=1.
- Accepted word: the handshake edge loads it. Its first bit is on data_out in the very next cycle, so latency is 0 cycles beyond the handshake edge.
- active is ignored mid-symbol. A drop never truncates a symbol in flight; the symbol finishes and COM follows.
- Reset asserted mid-symbol: the output goes to 0 immediately. After release the block restarts with a full SYNC_COUNT COM run.
- Simultaneous active 1→0 and in_valid=1 at a boundary: in_ready=0, the word is not consumed, COM is sent.
- link_up rises on the boundary edge that enters ACTIVE and falls on the edge that leaves it.

## Structure
- Shared package phy_pkg holds:
  - the COM (8'hBC) and IDL (8'h7C) default constants
  - the state enum {SYNC, ACTIVE}
  - the counter-width helper
- Submodule serializer_shift:
  - holds sh, cnt and the boundary strobe
  - parametrised by DATA_W and MSB_FIRST
  - has a load port
- Top level owns the FSM, com_cnt and the symbol mux.

## Test plan
- Defaults, active=1, in_valid=0:
  - Required: exactly 4 COMs (10111100) follow reset release.
  - link_up rises at clock 32 after release.
  - Then continuous IDL 01111100, with symbol_start every 8 clocks.
- ACTIVE, in_data=8'hA5 held valid for one boundary:
  - in_ready pulses one cycle.
  - Serial sequence is 1,0,1,0,0,1,0,1 starting the next clock.
  - IDL follows.
- active falls mid-symbol of 8'h3C:
  - 8'h3C completes intact.
  - 4 COMs follow; link_up=0 during them.
  - Data resumes only after active returns.
- Reset pulse at bit 3 of a data symbol:
  - data_out=0 during reset.
  - After release, 4 COMs are sent, with a new symbol_start at the first edge.
- DATA_W=10, MSB_FIRST=0, COM_SYM=10'h17C, SYNC_COUNT=2:
  - Required: 2 COMs LSB-first, symbol period 10 clocks.
  - in_data 10'h2AB is sent as 1,1,0,1,0,1,0,1,0,1.
- Back-to-back valid words 8'h01, 8'h02, 8'h03:
  - Contiguous 24-bit stream, no IDL between.
  - Exactly three in_ready pulses, spaced 8 clocks apart.
